// File: rtl/fifo_defines_pkg.sv
// ----------------------------------------------------------------------------
// fifo_defines_pkg
// Shared sizing parameters and types for the generator sample FIFO.
//   DATA_WIDTH : width of one signed sample
//   FIFO_DEPTH : number of entries (power of two)
//   FIFO_ADDR  : pointer width
//   AF_LEVEL   : almost-full threshold on the occupancy count
// No ports (package).
// ----------------------------------------------------------------------------
package fifo_defines_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_ADDR  = $clog2(FIFO_DEPTH);
    localparam int AF_LEVEL   = FIFO_DEPTH - 2;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;
    typedef logic        [FIFO_ADDR-1:0]  ptr_t;
    // One extra bit so that a completely full FIFO is distinguishable from empty.
    typedef logic        [FIFO_ADDR:0]    cnt_t;

    localparam cnt_t FULL_CNT = cnt_t'(FIFO_DEPTH);
    localparam cnt_t AF_CNT   = cnt_t'(AF_LEVEL);

    // Encoding is {write accepted, read accepted}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RW   = 2'b11
    } op_e;

    // Depth is a power of two, so natural overflow of the pointer is the wrap.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/gen_sample_fifo_if.sv
// ----------------------------------------------------------------------------
// gen_sample_fifo_if
// Bundles the producer/consumer side of the sample FIFO.
//   master : drives wr_en_i, data_i, rd_en_i; observes all FIFO outputs
//   slave  : the FIFO itself (inverse directions)
// Signal names keep the FIFO-centric _i/_o suffixes.
// ----------------------------------------------------------------------------
interface gen_sample_fifo_if;
    import fifo_defines_pkg::*;

    logic    wr_en_i;
    sample_t data_i;
    logic    rd_en_i;
    sample_t data_o;
    logic    valid_o;
    logic    full_o;
    logic    empty_o;
    logic    almost_full_o;
    cnt_t    count_o;
    logic    overflow_o;
    logic    underflow_o;

    modport master (
        output wr_en_i, data_i, rd_en_i,
        input  data_o, valid_o, full_o, empty_o, almost_full_o,
               count_o, overflow_o, underflow_o
    );

    modport slave (
        input  wr_en_i, data_i, rd_en_i,
        output data_o, valid_o, full_o, empty_o, almost_full_o,
               count_o, overflow_o, underflow_o
    );

endinterface

// File: rtl/gen_fifo_mem.sv
// ----------------------------------------------------------------------------
// gen_fifo_mem
// Dual-port sample storage: synchronous write port, registered read port.
//   clk     : rising-edge clock
//   rst     : synchronous active-low reset (read register only)
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   re_i    : read enable; rdata_o updates on the following edge
//   raddr_i : read address
//   rdata_o : registered read data, held while re_i is low
// The storage array is deliberately not reset.
// ----------------------------------------------------------------------------
module gen_fifo_mem
    import fifo_defines_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    we_i,
    input  ptr_t    waddr_i,
    input  sample_t wdata_i,
    input  logic    re_i,
    input  ptr_t    raddr_i,
    output sample_t rdata_o
);

    sample_t mem_q [FIFO_DEPTH];
    sample_t rdata_d;
    sample_t rdata_q;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Next read-register value: new entry on a read, otherwise hold.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[raddr_i];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read register; a same-edge write to raddr_i is not visible here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/gen_sample_fifo.sv
// ----------------------------------------------------------------------------
// gen_sample_fifo
// Synchronous FIFO buffering signed samples from the function generator.
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : gen_sample_fifo_if.slave
//         wr_en_i/data_i  write strobe and sample
//         rd_en_i         read request
//         data_o/valid_o  registered read data, valid one cycle after accept
//         full_o/empty_o/almost_full_o/count_o  occupancy status
//         overflow_o/underflow_o  sticky dropped-write / refused-read flags
// Pointers, count and flags live here; storage is in gen_fifo_mem.
// ----------------------------------------------------------------------------
module gen_sample_fifo
    import fifo_defines_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    gen_sample_fifo_if.slave bus
);

    ptr_t    wr_ptr_q, wr_ptr_d;
    ptr_t    rd_ptr_q, rd_ptr_d;
    cnt_t    count_q,  count_d;
    logic    full_q,   full_d;
    logic    empty_q,  empty_d;
    logic    af_q,     af_d;
    logic    valid_q,  valid_d;
    logic    ovf_q,    ovf_d;
    logic    unf_q,    unf_d;

    logic    rd_acc_s;
    logic    wr_acc_s;
    op_e     op_s;
    sample_t rdata_s;

    // Accept decisions, using only registered status so there is no bypass path.
    always_comb begin
        rd_acc_s = bus.rd_en_i & ~empty_q;
        // A write into a full FIFO is fine when a read frees a slot on the same edge.
        wr_acc_s = bus.wr_en_i & (~full_q | rd_acc_s);
        op_s     = op_e'({wr_acc_s, rd_acc_s});
    end

    // Next pointers, count, status flags and sticky error flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_acc_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case (op_s)
            OP_WR:   count_d = count_q + cnt_t'(1);
            OP_RD:   count_d = count_q - cnt_t'(1);
            OP_RW:   count_d = count_q;
            OP_IDLE: count_d = count_q;
            default: count_d = count_q;
        endcase

        // Status is registered from the next count, so it tracks count_q exactly.
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == cnt_t'(0));
        af_d    = (count_d >= AF_CNT);

        valid_d = rd_acc_s;
        ovf_d   = ovf_q | (bus.wr_en_i & ~wr_acc_s);
        unf_d   = unf_q | (bus.rd_en_i & empty_q);
    end

    // Control state register; reset also discards the inputs of that cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= ptr_t'(0);
            rd_ptr_q <= ptr_t'(0);
            count_q  <= cnt_t'(0);
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    gen_fifo_mem u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_acc_s & rst),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.data_i),
        .re_i    (rd_acc_s & rst),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata_s)
    );

    assign bus.data_o        = rdata_s;
    assign bus.valid_o       = valid_q;
    assign bus.full_o        = full_q;
    assign bus.empty_o       = empty_q;
    assign bus.almost_full_o = af_q;
    assign bus.count_o       = count_q;
    assign bus.overflow_o    = ovf_q;
    assign bus.underflow_o   = unf_q;

endmodule

// File: tb/tb_gen_sample_fifo.sv
// ----------------------------------------------------------------------------
// tb_gen_sample_fifo
// Self-checking bench for gen_sample_fifo. A reference queue models the FIFO
// contents; every accepted read pushes the expected sample onto a scoreboard
// which is popped when the DUT raises valid_o.
// ----------------------------------------------------------------------------
module tb_gen_sample_fifo;
    import fifo_defines_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    gen_sample_fifo_if bus ();

    gen_sample_fifo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int      vectors     = 0;
    int      miscompares = 0;

    sample_t mq [$];      // reference FIFO contents
    sample_t exp_q [$];   // scoreboard of samples due on data_o
    logic    exp_valid = 1'b0;
    logic    m_ovf     = 1'b0;
    logic    m_unf     = 1'b0;

    // Drive one cycle of stimulus, update the reference model, step past the edge.
    task automatic apply(input logic rs, input logic we, input sample_t d, input logic re);
        int   occ;
        logic rd_ok;
        logic wr_ok;
        rst         = rs;
        bus.wr_en_i = we;
        bus.data_i  = d;
        bus.rd_en_i = re;
        occ         = mq.size();
        if (!rs) begin
            mq.delete();
            exp_q.delete();
            m_ovf     = 1'b0;
            m_unf     = 1'b0;
            exp_valid = 1'b0;
        end else begin
            rd_ok = re && (occ != 0);
            wr_ok = we && ((occ < FIFO_DEPTH) || rd_ok);
            if (rd_ok) exp_q.push_back(mq.pop_front());
            if (wr_ok) mq.push_back(d);
            if (we && !wr_ok) m_ovf = 1'b1;
            if (re && (occ == 0)) m_unf = 1'b1;
            exp_valid = rd_ok;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply(1'b0, 1'b1, sample_t'(16'h7777), 1'b1);
        apply(1'b0, 1'b1, sample_t'(16'h7777), 1'b1);
        vectors++; if (bus.count_o !== cnt_t'(0)) begin miscompares++; $display("FAIL reset_count got %0d want 0", bus.count_o); end
        vectors++; if (bus.empty_o !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", bus.empty_o); end
        vectors++; if (bus.full_o !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", bus.full_o); end
        vectors++; if (bus.almost_full_o !== 1'b0) begin miscompares++; $display("FAIL reset_af got %b want 0", bus.almost_full_o); end
        vectors++; if (bus.valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", bus.valid_o); end
        vectors++; if (bus.data_o !== sample_t'(0)) begin miscompares++; $display("FAIL reset_data got %0d want 0", bus.data_o); end
        vectors++; if (bus.overflow_o !== 1'b0 || bus.underflow_o !== 1'b0) begin miscompares++; $display("FAIL reset_sticky got %b%b want 00", bus.overflow_o, bus.underflow_o); end
    endtask

    task automatic test_basic();
        sample_t vals [3];
        sample_t e;
        vals[0] = -16'sd5;
        vals[1] = 16'sd7;
        vals[2] = 16'sd32767;
        apply(1'b0, 1'b0, sample_t'(0), 1'b0);
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b1, vals[i], 1'b0);
        vectors++; if (bus.count_o !== cnt_t'(3)) begin miscompares++; $display("FAIL basic_count got %0d want 3", bus.count_o); end
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, sample_t'(0), 1'b1);
            vectors++; if (bus.valid_o !== 1'b1) begin miscompares++; $display("FAIL basic_valid[%0d] got %b want 1", i, bus.valid_o); end
            if (bus.valid_o === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++; if (bus.data_o !== e) begin miscompares++; $display("FAIL basic_data[%0d] got %0d want %0d", i, bus.data_o, e); end
                vectors++; if (bus.data_o !== vals[i]) begin miscompares++; $display("FAIL basic_order[%0d] got %0d want %0d", i, bus.data_o, vals[i]); end
            end
        end
        apply(1'b1, 1'b0, sample_t'(0), 1'b0);
        vectors++; if (bus.empty_o !== 1'b1) begin miscompares++; $display("FAIL basic_empty got %b want 1", bus.empty_o); end
        vectors++; if (bus.valid_o !== 1'b0) begin miscompares++; $display("FAIL basic_idle_valid got %b want 0", bus.valid_o); end
        vectors++; if (bus.data_o !== 16'sd32767) begin miscompares++; $display("FAIL basic_hold got %0d want 32767", bus.data_o); end
    endtask

    task automatic test_full_overflow();
        sample_t e;
        apply(1'b0, 1'b0, sample_t'(0), 1'b0);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            apply(1'b1, 1'b1, sample_t'(i * 1000 - 8000), 1'b0);
            vectors++; if (bus.almost_full_o !== (mq.size() >= AF_LEVEL)) begin miscompares++; $display("FAIL af_level[%0d] got %b want %b", i, bus.almost_full_o, mq.size() >= AF_LEVEL); end
            vectors++; if (bus.full_o !== (mq.size() == FIFO_DEPTH)) begin miscompares++; $display("FAIL full_level[%0d] got %b want %b", i, bus.full_o, mq.size() == FIFO_DEPTH); end
        end
        vectors++; if (bus.count_o !== cnt_t'(16)) begin miscompares++; $display("FAIL full_count got %0d want 16", bus.count_o); end
        apply(1'b1, 1'b1, sample_t'(16'h1234), 1'b0);
        vectors++; if (bus.overflow_o !== 1'b1) begin miscompares++; $display("FAIL ovf_set got %b want 1", bus.overflow_o); end
        vectors++; if (bus.count_o !== cnt_t'(16)) begin miscompares++; $display("FAIL ovf_count got %0d want 16", bus.count_o); end
        apply(1'b1, 1'b0, sample_t'(0), 1'b1);
        vectors++; if (bus.valid_o !== 1'b1) begin miscompares++; $display("FAIL ovf_rd_valid got %b want 1", bus.valid_o); end
        if (bus.valid_o === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++; if (bus.data_o !== e) begin miscompares++; $display("FAIL ovf_first got %0d want %0d", bus.data_o, e); end
        end
        vectors++; if (bus.overflow_o !== m_ovf) begin miscompares++; $display("FAIL ovf_sticky got %b want %b", bus.overflow_o, m_ovf); end
    endtask

    task automatic test_full_rw();
        sample_t e;
        apply(1'b0, 1'b0, sample_t'(0), 1'b0);
        for (int i = 0; i < FIFO_DEPTH; i++) apply(1'b1, 1'b1, sample_t'(i * 37 - 300), 1'b0);
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b1, sample_t'(-(i + 1) * 111), 1'b1);
            vectors++; if (bus.count_o !== cnt_t'(16)) begin miscompares++; $display("FAIL rw_count[%0d] got %0d want 16", i, bus.count_o); end
            vectors++; if (bus.overflow_o !== 1'b0) begin miscompares++; $display("FAIL rw_ovf[%0d] got %b want 0", i, bus.overflow_o); end
            vectors++; if (bus.valid_o !== exp_valid) begin miscompares++; $display("FAIL rw_valid[%0d] got %b want %b", i, bus.valid_o, exp_valid); end
            if (bus.valid_o === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++; if (bus.data_o !== e) begin miscompares++; $display("FAIL rw_data[%0d] got %0d want %0d", i, bus.data_o, e); end
            end
        end
    endtask

    task automatic test_empty_underflow();
        sample_t e;
        apply(1'b0, 1'b0, sample_t'(0), 1'b0);
        apply(1'b1, 1'b1, sample_t'(9), 1'b1);
        vectors++; if (bus.valid_o !== 1'b0) begin miscompares++; $display("FAIL unf_valid got %b want 0", bus.valid_o); end
        vectors++; if (bus.underflow_o !== 1'b1) begin miscompares++; $display("FAIL unf_set got %b want 1", bus.underflow_o); end
        vectors++; if (bus.count_o !== cnt_t'(1)) begin miscompares++; $display("FAIL unf_wr_count got %0d want 1", bus.count_o); end
        apply(1'b1, 1'b0, sample_t'(0), 1'b1);
        vectors++; if (bus.valid_o !== 1'b1) begin miscompares++; $display("FAIL unf_rd_valid got %b want 1", bus.valid_o); end
        if (bus.valid_o === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++; if (bus.data_o !== e || e !== sample_t'(9)) begin miscompares++; $display("FAIL unf_rd_data got %0d want 9", bus.data_o); end
        end
    endtask

    task automatic test_wrap();
        sample_t e;
        int      writes = 0;
        int      reads  = 0;
        int      occ;
        logic    we;
        logic    re;
        apply(1'b0, 1'b0, sample_t'(0), 1'b0);
        for (int cyc = 0; cyc < 400 && (writes < 40 || mq.size() > 0); cyc++) begin
            occ = mq.size();
            if (writes >= 40) begin
                we = 1'b0; re = 1'b1;
            end else if (occ <= 1) begin
                we = 1'b1; re = (occ == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            end else if (occ >= 3) begin
                we = 1'($urandom_range(0, 1)); re = 1'b1;
            end else begin
                we = 1'($urandom_range(0, 1)); re = 1'($urandom_range(0, 1));
            end
            if (we) writes++;
            apply(1'b1, we, sample_t'($urandom_range(0, 65535)), re);
            vectors++; if (bus.count_o !== cnt_t'(mq.size())) begin miscompares++; $display("FAIL wrap_count[%0d] got %0d want %0d", cyc, bus.count_o, mq.size()); end
            vectors++; if (bus.valid_o !== exp_valid) begin miscompares++; $display("FAIL wrap_valid[%0d] got %b want %b", cyc, bus.valid_o, exp_valid); end
            if (bus.valid_o === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                reads++;
                vectors++; if (bus.data_o !== e) begin miscompares++; $display("FAIL wrap_data[%0d] got %0d want %0d", reads, bus.data_o, e); end
            end
        end
        vectors++; if (reads !== 40) begin miscompares++; $display("FAIL wrap_reads got %0d want 40", reads); end
        vectors++; if (bus.empty_o !== 1'b1) begin miscompares++; $display("FAIL wrap_empty got %b want 1", bus.empty_o); end
    endtask

    task automatic test_reset_midstream();
        sample_t e;
        apply(1'b0, 1'b0, sample_t'(0), 1'b0);
        apply(1'b1, 1'b0, sample_t'(0), 1'b1);
        for (int i = 0; i < 10; i++) apply(1'b1, 1'b1, sample_t'(i + 100), 1'b0);
        vectors++; if (bus.count_o !== cnt_t'(10)) begin miscompares++; $display("FAIL mid_pre_count got %0d want 10", bus.count_o); end
        apply(1'b1, 1'b0, sample_t'(0), 1'b1);
        if (bus.valid_o === 1'b1 && exp_q.size() > 0) e = exp_q.pop_front();
        apply(1'b0, 1'b1, sample_t'(16'h4444), 1'b1);
        vectors++; if (bus.count_o !== cnt_t'(0)) begin miscompares++; $display("FAIL mid_count got %0d want 0", bus.count_o); end
        vectors++; if (bus.empty_o !== 1'b1) begin miscompares++; $display("FAIL mid_empty got %b want 1", bus.empty_o); end
        vectors++; if (bus.underflow_o !== 1'b0 || bus.overflow_o !== 1'b0) begin miscompares++; $display("FAIL mid_sticky got %b%b want 00", bus.overflow_o, bus.underflow_o); end
        vectors++; if (bus.valid_o !== 1'b0 || bus.data_o !== sample_t'(0)) begin miscompares++; $display("FAIL mid_out got %b/%0d want 0/0", bus.valid_o, bus.data_o); end
        apply(1'b1, 1'b1, sample_t'(16'h0055), 1'b0);
        vectors++; if (bus.count_o !== cnt_t'(1)) begin miscompares++; $display("FAIL mid_first_wr got %0d want 1", bus.count_o); end
        apply(1'b1, 1'b0, sample_t'(0), 1'b1);
        if (bus.valid_o === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++; if (bus.data_o !== e || e !== sample_t'(16'h0055)) begin miscompares++; $display("FAIL mid_rd_data got %0d want 85", bus.data_o); end
        end else begin
            vectors++; miscompares++; $display("FAIL mid_rd_valid got %b want 1", bus.valid_o);
        end
    endtask

    initial begin
        bus.wr_en_i = 1'b0;
        bus.data_i  = sample_t'(0);
        bus.rd_en_i = 1'b0;
        test_reset();
        test_basic();
        test_full_overflow();
        test_full_rw();
        test_empty_underflow();
        test_wrap();
        test_reset_midstream();
        vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
